// File: rtl/disp_mux_4digit.sv
// disp_mux_4digit: time-multiplexed 4-digit seven-segment scanner with blanking and frame tick
//   Ports: clk_i, rst_ni (async active-low), en_i (scan enable), in0_i..in3_i (active-high {g..a}),
//   dp_in_i (per-digit decimal point), segment_o/dp_o/anode_o (active-low, registered),
//   digit_sel_o (digit in its slot), frame_tick_o (pulse on digit 3 -> 0 wrap).
//   Optional DISP_MUX_PWM_EN adds bright_i (0..15) to PWM the anode during the active slot part.
module disp_mux_4digit #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [6:0] in0_i,
  input  logic [6:0] in1_i,
  input  logic [6:0] in2_i,
  input  logic [6:0] in3_i,
  input  logic [3:0] dp_in_i,
`ifdef DISP_MUX_PWM_EN
  input  logic [3:0] bright_i,
`endif
  output logic [6:0] segment_o,
  output logic       dp_o,
  output logic [3:0] anode_o,
  output logic [1:0] digit_sel_o,
  output logic       frame_tick_o
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);
  logic [CW-1:0] slot_q, slot_d, slot_eff;
  logic [1:0] digit_q, digit_d;
  logic en_q;
  logic [6:0] shadow_q, shadow_d, in_sel, segment_q, segment_d;
  logic sdp_q, sdp_d, dp_q, dp_d, tick_q, tick_d;
  logic [3:0] anode_q, anode_d;
  logic last, snap, active, lit;
`ifdef DISP_MUX_PWM_EN
  logic [3:0] pwm_cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) pwm_cnt_q <= '0;
    else         pwm_cnt_q <= pwm_cnt_q + 4'd1;
`endif
  // A slot resumed after en_i was low restarts from count 0 so blanking and the snapshot repeat.
  always_comb begin
    slot_eff  = en_q ? slot_q : '0;
    last      = slot_eff == LAST;
    in_sel    = digit_q == 2'd0 ? in0_i : digit_q == 2'd1 ? in1_i : digit_q == 2'd2 ? in2_i : in3_i;
    snap      = en_i && slot_eff == '0;
    shadow_d  = snap ? in_sel : shadow_q;
    sdp_d     = snap ? dp_in_i[digit_q] : sdp_q;
    slot_d    = en_i ? (last ? '0 : slot_eff + 1'b1) : slot_q;
    digit_d   = (en_i && last) ? digit_q + 2'd1 : digit_q;
    active    = en_i && slot_eff >= BLANK;
`ifdef DISP_MUX_PWM_EN
    lit       = active && pwm_cnt_q < bright_i;
`else
    lit       = active;
`endif
    anode_d   = lit ? ~(4'b0001 << digit_q) : 4'hF;
    segment_d = active ? ~shadow_d : 7'h7F;
    dp_d      = active ? ~sdp_d : 1'b1;
    tick_d    = en_i && last && digit_q == 2'd3;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q    <= '0;
      digit_q   <= '0;
      en_q      <= 1'b0;
      shadow_q  <= '0;
      sdp_q     <= 1'b0;
      anode_q   <= 4'hF;
      segment_q <= 7'h7F;
      dp_q      <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      slot_q    <= slot_d;
      digit_q   <= digit_d;
      en_q      <= en_i;
      shadow_q  <= shadow_d;
      sdp_q     <= sdp_d;
      anode_q   <= anode_d;
      segment_q <= segment_d;
      dp_q      <= dp_d;
      tick_q    <= tick_d;
    end
  end
  assign segment_o    = segment_q;
  assign dp_o         = dp_q;
  assign anode_o      = anode_q;
  assign digit_sel_o  = digit_q;
  assign frame_tick_o = tick_q;
endmodule

// File: tb/tb_disp_mux_4digit.sv
// tb_disp_mux_4digit: table-driven, hand-sequenced and randomized checks of disp_mux_4digit
module tb_disp_mux_4digit;
  localparam int RD = 8;
  localparam int BL = 2;
  typedef struct {
    logic [6:0] pat;
    logic       dpb;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dpo;
  } vec_t;
  vec_t tab[4];
  logic clk = 1'b0;
  logic rst_n;
  logic en = 1'b1;
  logic [6:0] din[4];
  logic [3:0] dp_in = 4'h0;
  logic [6:0] segment;
  logic dp, frame_tick;
  logic [3:0] anode;
  logic [1:0] digit_sel;
`ifdef DISP_MUX_PWM_EN
  logic [3:0] bright = 4'd4;
`endif
  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;
  always #5 clk = ~clk;
  disp_mux_4digit #(.REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en),
    .in0_i(din[0]), .in1_i(din[1]), .in2_i(din[2]), .in3_i(din[3]),
    .dp_in_i(dp_in),
`ifdef DISP_MUX_PWM_EN
    .bright_i(bright),
`endif
    .segment_o(segment), .dp_o(dp), .anode_o(anode),
    .digit_sel_o(digit_sel), .frame_tick_o(frame_tick));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_anode(input logic [3:0] a, input string name);
    for (int i = 0; i < 100 && anode !== a; i++) step();
    chk(name, anode === a, 1);
  endtask
  // Reference model: counts enabled clocks spent in the current slot (age) and total completed
  // slots; the digit is slots mod 4, the bus is lit once age reaches the blanking length.
  int m_age, m_slots, m_pwm;
  logic [6:0] m_snap, e_seg;
  logic m_sdp, e_dp, e_tick;
  logic [3:0] e_an;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age <= 0; m_slots <= 0; m_pwm <= 0; m_snap <= '0; m_sdp <= 1'b0;
      e_an <= 4'hF; e_seg <= 7'h7F; e_dp <= 1'b1; e_tick <= 1'b0;
    end else begin : model_step
      int d;
      logic [6:0] s;
      logic sd;
      bit on;
      m_pwm <= m_pwm + 1;
      if (!en) begin
        m_age <= 0; e_an <= 4'hF; e_seg <= 7'h7F; e_dp <= 1'b1; e_tick <= 1'b0;
      end else begin
        d  = m_slots % 4;
        s  = (m_age == 0) ? din[d] : m_snap;
        sd = (m_age == 0) ? dp_in[d] : m_sdp;
        m_snap <= s;
        m_sdp  <= sd;
        on = m_age >= BL;
        e_seg <= on ? ~s : 7'h7F;
        e_dp  <= on ? ~sd : 1'b1;
`ifdef DISP_MUX_PWM_EN
        on = on && (m_pwm % 16) < int'(bright);
`endif
        e_an   <= on ? ~(4'b0001 << d) : 4'hF;
        e_tick <= (m_age == RD - 1) && d == 3;
        if (m_age == RD - 1) begin
          m_age <= 0; m_slots <= m_slots + 1;
        end else m_age <= m_age + 1;
      end
    end
  end
  always @(negedge clk) if (chk_on) begin
    chk("anode", anode, e_an);
    chk("segment", segment, e_seg);
    chk("dp", dp, e_dp);
    chk("frame_tick", frame_tick, e_tick);
    chk("digit_sel", digit_sel, 32'(m_slots % 4));
    chk("one_anode", $countones(~anode) <= 1, 1);
  end
  initial begin
    tab[0] = '{7'h3F, 1'b0, 7'h40, 4'b1110, 1'b1};
    tab[1] = '{7'h06, 1'b0, 7'h79, 4'b1101, 1'b1};
    tab[2] = '{7'h5B, 1'b1, 7'h24, 4'b1011, 1'b0};
    tab[3] = '{7'h4F, 1'b0, 7'h30, 4'b0111, 1'b1};
    for (int i = 0; i < 4; i++) begin
      din[i] = tab[i].pat;
      dp_in[i] = tab[i].dpb;
    end
    rst_n = 1'b0;
    step();
    chk_on = 1'b1;
    step();
    chk("rst_anode", anode, 4'hF);
    chk("rst_segment", segment, 7'h7F);
    chk("rst_dp", dp, 1);
    chk("rst_tick", frame_tick, 0);
    chk("rst_digit_sel", digit_sel, 0);
    rst_n = 1'b1;
`ifndef DISP_MUX_PWM_EN
    for (int k = 1; k <= 9; k++) begin
      step();
      chk("t1_anode", anode, (k >= 3 && k <= 8) ? 4'b1110 : 4'hF);
    end
    for (int i = 0; i < 4; i++) begin : table_loop
      int n;
      int m;
      wait_anode(tab[i].an, "t2_wait");
      chk("t2_segment", segment, tab[i].seg);
      chk("t2_dp", dp, tab[i].dpo);
      n = 0;
      for (int j = 0; j < 20 && anode === tab[i].an; j++) begin n++; step(); end
      chk("t2_lit_len", n, 6);
      m = 0;
      for (int j = 0; j < 20 && anode === 4'hF; j++) begin m++; step(); end
      chk("t2_gap", m, 2);
    end
    begin : frame_test
      int last;
      int pulses;
      bit prev;
      last = -1; pulses = 0; prev = 1'b0;
      for (int c = 0; c < 96; c++) begin
        step();
        chk("t3_width", prev & frame_tick, 0);
        if (frame_tick) begin
          if (last >= 0) chk("t3_period", c - last, 32);
          last = c;
          pulses++;
        end
        prev = frame_tick;
      end
      chk("t3_pulses", pulses, 3);
    end
    wait_anode(4'b1101, "t4_wait");
    step();
    din[1] = 7'h7F;
    for (int j = 0; j < 10 && anode === 4'b1101; j++) begin
      chk("t4_hold", segment, 7'h79);
      step();
    end
    wait_anode(4'b1101, "t4_wait2");
    chk("t4_new", segment, 7'h00);
    din[1] = 7'h06;
    wait_anode(4'b1011, "t5_wait");
    step();
    en = 1'b0;
    step();
    chk("t5_dark_anode", anode, 4'hF);
    chk("t5_dark_seg", segment, 7'h7F);
    chk("t5_sel", digit_sel, 2);
    repeat (5) step();
    chk("t5_hold_sel", digit_sel, 2);
    en = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk("t5_anode", anode, (k >= 3 && k <= 8) ? 4'b1011 : 4'hF);
    end
`else
    bright = 4'd0;
    for (int k = 0; k < 64; k++) begin
      step();
      chk("pwm_zero", anode, 4'hF);
    end
    bright = 4'd4;
    begin : pwm_test
      int lit;
      lit = 0;
      for (int k = 0; k < 128; k++) begin
        step();
        if (anode !== 4'hF) lit++;
      end
      chk("pwm_some_lit", lit > 0 && lit <= 32, 1);
    end
`endif
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_anode", anode, 4'hF);
    chk("midrst_segment", segment, 7'h7F);
    chk("midrst_dp", dp, 1);
    chk("midrst_sel", digit_sel, 0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 400; c++) begin
      step();
      if ($urandom_range(7) == 0) din[$urandom_range(3)] = 7'($urandom);
      if ($urandom_range(7) == 0) dp_in = 4'($urandom);
      en = $urandom_range(9) != 0;
`ifdef DISP_MUX_PWM_EN
      if ($urandom_range(15) == 0) bright = 4'($urandom);
`endif
      if ($urandom_range(99) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
    end
    step();
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
